// File: rtl/cpu_controller.sv
// VeriRISC phase sequencer: steps each instruction through 8 phases and decodes control strobes.
// Strobes are combinational from the registered phase; sticky HALTED until reset; counts retired instructions.
package opcodes;
    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;
endpackage

module cpu_controller
    import opcodes::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       opcode,
    input  logic             zero,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             load_ir,
    output logic             inc_pc,
    output logic             load_pc,
    output logic             load_ac,
    output logic             halt,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] instr_cnt
);

    // Phase states share their encoding with the phase output; HALTED sits outside 0..7.
    typedef enum logic [3:0] {
        INST_ADDR  = 4'd0,
        INST_FETCH = 4'd1,
        INST_LOAD  = 4'd2,
        IDLE       = 4'd3,
        OP_ADDR    = 4'd4,
        OP_FETCH   = 4'd5,
        ALU_OP     = 4'd6,
        STORE      = 4'd7,
        HALTED     = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    opcode_t          op;
    logic             is_aluop;

    assign op = opcode_t'(opcode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INST_ADDR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        is_aluop = 1'b0;
        case (op)
            ADD, AND, XOR, LDA: is_aluop = 1'b1;
            default:            is_aluop = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        load_ir = 1'b0;
        inc_pc  = 1'b0;
        load_pc = 1'b0;
        load_ac = 1'b0;
        halt    = 1'b0;
        case (state_q)
            INST_ADDR: begin
                state_d = INST_FETCH;
            end
            INST_FETCH: begin
                state_d = INST_LOAD;
                mem_rd  = 1'b1;
            end
            INST_LOAD: begin
                state_d = IDLE;
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            IDLE: begin
                state_d = OP_ADDR;
                mem_rd  = 1'b1;
                load_ir = 1'b1;
            end
            OP_ADDR: begin
                state_d = (op == HLT) ? HALTED : OP_FETCH;
                inc_pc  = (op != HLT);
                halt    = (op == HLT);
            end
            OP_FETCH: begin
                state_d = ALU_OP;
                mem_rd  = is_aluop;
            end
            ALU_OP: begin
                // zero only matters here: it is the SKZ skip condition.
                state_d = STORE;
                mem_rd  = is_aluop;
                load_ac = is_aluop;
                inc_pc  = (op == SKZ) && zero;
                load_pc = (op == JMP);
            end
            STORE: begin
                state_d = INST_ADDR;
                cnt_d   = cnt_q + CNT_W'(1);
                mem_rd  = is_aluop;
                load_ac = is_aluop;
                inc_pc  = (op == JMP);
                load_pc = (op == JMP);
                mem_wr  = (op == STO);
            end
            HALTED: begin
                halt = 1'b1;
            end
            default: begin
                state_d = INST_ADDR;
            end
        endcase
    end

    assign phase     = (state_q == HALTED) ? 3'd0 : state_q[2:0];
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Randomized bench for cpu_controller: a phase/halt/count model predicts every output each cycle.
module tb_cpu_controller;

    localparam int CNT_W = 2;

    logic             clk;
    logic             rst;
    logic [2:0]       opcode;
    logic             zero;
    logic             mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac, halt;
    logic [2:0]       phase;
    logic [CNT_W-1:0] instr_cnt;

    cpu_controller #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .zero      (zero),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .load_ir   (load_ir),
        .inc_pc    (inc_pc),
        .load_pc   (load_pc),
        .load_ac   (load_ac),
        .halt      (halt),
        .phase     (phase),
        .instr_cnt (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase number, halted flag, retired count (modulo 2**CNT_W).
    int m_phase  = 0;
    bit m_halted = 0;
    int m_cnt    = 0;

    function automatic logic [11:0] obs();
        return {mem_rd, mem_wr, load_ir, inc_pc, load_pc, load_ac, halt, phase, instr_cnt};
    endfunction

    function automatic logic [11:0] exp_vec();
        logic rd, wr, ir, ipc, lpc, lac, h, alu;
        int o;
        o = int'(opcode);
        alu = (o >= 2) && (o <= 5);
        {rd, wr, ir, ipc, lpc, lac, h} = 7'b0;
        if (m_halted) h = 1'b1;
        else begin
            case (m_phase)
                1: rd = 1'b1;
                2, 3: begin rd = 1'b1; ir = 1'b1; end
                4: begin ipc = (o != 0); h = (o == 0); end
                5: rd = alu;
                6: begin rd = alu; lac = alu; ipc = (o == 1) && zero; lpc = (o == 7); end
                7: begin rd = alu; lac = alu; ipc = (o == 7); lpc = (o == 7); wr = (o == 6); end
                default: ;
            endcase
        end
        return {rd, wr, ir, ipc, lpc, lac, h, (m_halted ? 3'd0 : 3'(m_phase)), 2'(m_cnt)};
    endfunction

    task automatic drive(input logic [2:0] op, input logic z);
        opcode = op;
        zero   = z;
        #1;
    endtask

    // Rising edge: model moves one phase (unless reset is held), then back to the falling edge.
    task automatic advance();
        @(posedge clk);
        if (!rst) begin
            if (m_halted) begin
            end else if (m_phase == 4 && opcode == 3'd0) begin
                m_halted = 1;
            end else begin
                if (m_phase == 7) m_cnt = (m_cnt + 1) % (1 << CNT_W);
                m_phase = (m_phase + 1) % 8;
            end
        end
        @(negedge clk);
    endtask

    task automatic assert_rst();
        rst      = 1'b1;
        m_phase  = 0;
        m_halted = 0;
        m_cnt    = 0;
    endtask

    task automatic test_reset();
        assert_rst();
        drive(3'd6, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive(3'($urandom_range(0, 7)), 1'($urandom));
            n_checks++;
            if (obs() !== exp_vec()) $display("FAIL reset_hold obs=%b exp=%b", obs(), exp_vec());
            else n_pass++;
            advance();
        end
        rst = 1'b0;
        // Walk an STO up to STORE, then reset asynchronously in the middle of it.
        for (int p = 0; p < 8; p++) begin
            drive(3'd6, 1'b0);
            n_checks++;
            if (obs() !== exp_vec()) $display("FAIL sto_walk p=%0d obs=%b exp=%b", p, obs(), exp_vec());
            else n_pass++;
            if (p < 7) advance();
        end
        n_checks++;
        if (mem_wr !== 1'b1) $display("FAIL sto_mem_wr obs=%b exp=1", mem_wr);
        else n_pass++;
        #1;
        assert_rst();
        #1;
        n_checks++;
        if (obs() !== 12'b0) $display("FAIL async_reset obs=%b exp=%b", obs(), 12'b0);
        else n_pass++;
        advance();
        rst = 1'b0;
        drive(3'd6, 1'b0);
        n_checks++;
        if (obs() !== exp_vec()) $display("FAIL after_reset obs=%b exp=%b", obs(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_add();
        logic [7:0] rd_mask, ac_mask;
        int c0;
        rd_mask = '0;
        ac_mask = '0;
        c0 = m_cnt;
        for (int p = 0; p < 8; p++) begin
            drive(3'd2, 1'($urandom));
            rd_mask[p] = mem_rd;
            ac_mask[p] = load_ac;
            n_checks++;
            if (obs() !== exp_vec()) $display("FAIL add p=%0d obs=%b exp=%b", p, obs(), exp_vec());
            else n_pass++;
            advance();
        end
        n_checks++;
        if (rd_mask !== 8'b1110_1110 || ac_mask !== 8'b1100_0000)
            $display("FAIL add_masks rd=%b ac=%b exp rd=11101110 ac=11000000", rd_mask, ac_mask);
        else n_pass++;
        n_checks++;
        if (int'(instr_cnt) !== (c0 + 1) % 4) $display("FAIL add_cnt obs=%0d exp=%0d", instr_cnt, (c0 + 1) % 4);
        else n_pass++;
    endtask

    task automatic test_skz();
        for (int z = 1; z >= 0; z--) begin
            int pulses;
            pulses = 0;
            for (int p = 0; p < 8; p++) begin
                drive(3'd1, 1'(z));
                pulses += int'(inc_pc);
                n_checks++;
                if (obs() !== exp_vec()) $display("FAIL skz z=%0d p=%0d obs=%b exp=%b", z, p, obs(), exp_vec());
                else n_pass++;
                advance();
            end
            n_checks++;
            if (pulses != (z ? 2 : 1)) $display("FAIL skz_pulses z=%0d obs=%0d exp=%0d", z, pulses, z ? 2 : 1);
            else n_pass++;
        end
    endtask

    task automatic test_jmp();
        logic [7:0] lpc_mask, ipc_mask;
        for (int p = 0; p < 8; p++) begin
            drive(3'd7, 1'($urandom));
            lpc_mask[p] = load_pc;
            ipc_mask[p] = inc_pc;
            n_checks++;
            if (obs() !== exp_vec()) $display("FAIL jmp p=%0d obs=%b exp=%b", p, obs(), exp_vec());
            else n_pass++;
            advance();
        end
        n_checks++;
        if (lpc_mask !== 8'b1100_0000 || ipc_mask !== 8'b1001_0000)
            $display("FAIL jmp_masks lpc=%b ipc=%b exp lpc=11000000 ipc=10010000", lpc_mask, ipc_mask);
        else n_pass++;
    endtask

    task automatic test_halt();
        for (int p = 0; p < 5; p++) begin
            drive(3'd0, 1'($urandom));
            n_checks++;
            if (obs() !== exp_vec()) $display("FAIL hlt p=%0d obs=%b exp=%b", p, obs(), exp_vec());
            else n_pass++;
            if (p == 4) begin
                n_checks++;
                if (halt !== 1'b1 || inc_pc !== 1'b0) $display("FAIL hlt_op_addr halt=%b inc_pc=%b exp 1/0", halt, inc_pc);
                else n_pass++;
            end
            advance();
        end
        for (int i = 0; i < 20; i++) begin
            drive(3'($urandom_range(0, 7)), 1'($urandom));
            n_checks++;
            if (halt !== 1'b1 || phase !== 3'd0 || obs() !== exp_vec())
                $display("FAIL halted i=%0d obs=%b exp=%b", i, obs(), exp_vec());
            else n_pass++;
            advance();
        end
        assert_rst();
        advance();
        rst = 1'b0;
        drive(3'd2, 1'b0);
        n_checks++;
        if (obs() !== exp_vec() || halt !== 1'b0) $display("FAIL hlt_release obs=%b exp=%b", obs(), exp_vec());
        else n_pass++;
    endtask

    task automatic test_sto_wrap();
        int exp_cnt [5] = '{1, 2, 3, 0, 1};
        int wr_bad;
        assert_rst();
        advance();
        rst = 1'b0;
        wr_bad = 0;
        for (int k = 0; k < 5; k++) begin
            for (int p = 0; p < 8; p++) begin
                drive(3'd6, 1'($urandom));
                if (mem_wr !== (p == 7)) wr_bad++;
                n_checks++;
                if (obs() !== exp_vec()) $display("FAIL sto k=%0d p=%0d obs=%b exp=%b", k, p, obs(), exp_vec());
                else n_pass++;
                advance();
            end
            n_checks++;
            if (int'(instr_cnt) !== exp_cnt[k]) $display("FAIL sto_cnt k=%0d obs=%0d exp=%0d", k, instr_cnt, exp_cnt[k]);
            else n_pass++;
        end
        n_checks++;
        if (wr_bad != 0) $display("FAIL sto_mem_wr_phase obs=%0d bad cycles exp=0", wr_bad);
        else n_pass++;
    endtask

    task automatic test_random();
        int halted_for;
        halted_for = 0;
        for (int i = 0; i < 400; i++) begin
            drive(3'($urandom_range(0, 7)), 1'($urandom));
            n_checks++;
            if (obs() !== exp_vec() || (mem_rd && mem_wr) || (load_pc && opcode != 3'd7))
                $display("FAIL random i=%0d obs=%b exp=%b", i, obs(), exp_vec());
            else n_pass++;
            halted_for = m_halted ? halted_for + 1 : 0;
            if (halted_for > 3 || $urandom_range(0, 49) == 0) begin
                assert_rst();
                #1;
                n_checks++;
                if (obs() !== exp_vec()) $display("FAIL random_rst i=%0d obs=%b exp=%b", i, obs(), exp_vec());
                else n_pass++;
                advance();
                rst = 1'b0;
                halted_for = 0;
            end else begin
                advance();
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 3'd0;
        zero   = 1'b0;
        test_reset();
        test_add();
        test_skz();
        test_jmp();
        test_halt();
        test_sto_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
